// File: rtl/temp_pkg.sv
// Shared types, glyph codes and helpers for the temperature display slice.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package temp_pkg;

  localparam int RAW_W = 12;
  localparam int INT_W = 8;
  localparam int BCD_W = 12;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [3:0] {
    DIG_0     = 4'd0,
    DIG_1     = 4'd1,
    DIG_2     = 4'd2,
    DIG_3     = 4'd3,
    DIG_4     = 4'd4,
    DIG_5     = 4'd5,
    DIG_6     = 4'd6,
    DIG_7     = 4'd7,
    DIG_8     = 4'd8,
    DIG_9     = 4'd9,
    DIG_MINUS = 4'd10,
    DIG_BLANK = 4'd11
  } digit_t;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CONV = 2'd1;
  localparam state_t LOAD = 2'd2;

  function automatic logic [6:0] seg_encode(digit_t d);
    case (d)
      DIG_0:     return SEG_0;
      DIG_1:     return SEG_1;
      DIG_2:     return SEG_2;
      DIG_3:     return SEG_3;
      DIG_4:     return SEG_4;
      DIG_5:     return SEG_5;
      DIG_6:     return SEG_6;
      DIG_7:     return SEG_7;
      DIG_8:     return SEG_8;
      DIG_9:     return SEG_9;
      DIG_MINUS: return SEG_MINUS;
      default:   return SEG_BLANK;
    endcase
  endfunction

  // Whole-degree magnitude, truncated toward zero; 0x800 negates to 2048 -> 128.
  function automatic logic [INT_W-1:0] raw_to_int(logic [RAW_W-1:0] raw);
    return raw[RAW_W-1] ? INT_W'((~raw + 1'b1) >> 4) : raw[RAW_W-1:4];
  endfunction

endpackage

// File: rtl/temp_display_bin2bcd.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD in exactly 8 cycles.
// done_o is high during the final shift cycle; bcd_o holds the result from the next cycle on.
module bin2bcd_seq
  import temp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [INT_W-1:0] bin_i,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BCD_W+INT_W-1:0] sr_q, sr_d, adj;
  logic [2:0]             cnt_q, cnt_d;
  logic                   active_q, active_d;

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (sr_q[INT_W + 4*i +: 4] >= 4'd5) begin
        adj[INT_W + 4*i +: 4] = sr_q[INT_W + 4*i +: 4] + 4'd3;
      end
    end

    sr_d     = sr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start_i) begin
      sr_d     = {{BCD_W{1'b0}}, bin_i};
      cnt_d    = 3'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      sr_d  = adj << 1;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q     <= '0;
      cnt_q    <= 3'd0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o = active_q && (cnt_q == 3'd7);
  assign bcd_o  = sr_q[INT_W +: BCD_W];

endmodule

// File: rtl/temp_display.sv
// Temperature display: periodic sensor start, reading capture, BCD conversion, 4-digit scan.
// Define TEMP_LZB_EN to blank leading zeros of the magnitude digits.
module temp_display
  import temp_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int SCAN_DIV      = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        data_valid,
  output logic        start,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int SP_W = $clog2(SAMPLE_PERIOD);
  localparam int SD_W = $clog2(SCAN_DIV);
  localparam logic [SP_W-1:0] SAMPLE_LAST = SP_W'(SAMPLE_PERIOD - 1);
  localparam logic [SD_W-1:0] SCAN_LAST   = SD_W'(SCAN_DIV - 1);

  logic [SP_W-1:0]      sample_cnt_q, sample_cnt_d;
  logic                 start_q;
  logic [SD_W-1:0]      scan_cnt_q, scan_cnt_d;
  logic [1:0]           scan_idx_q, scan_idx_d;
  logic [3:0]           an_q;
  logic [6:0]           seg_q;

  state_t               state_q, state_d;
  logic [RAW_W-1:0]     raw_q, raw_d;
  logic [RAW_W-1:0]     pend_val_q, pend_val_d;
  logic                 pend_q, pend_d;
  logic                 busy_q;
  logic [3:0][3:0]      disp_q, disp_d, load_digits;

  logic [RAW_W-1:0]     conv_raw;
  logic                 conv_start, conv_done;
  logic [BCD_W-1:0]     conv_bcd;
  logic                 data_unused;

  assign data_unused = ^data[3:0];

  always_comb begin
    sample_cnt_d = (sample_cnt_q == SAMPLE_LAST) ? '0 : sample_cnt_q + 1'b1;
    scan_cnt_d   = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d   = (scan_cnt_q == SCAN_LAST) ? scan_idx_q + 2'd1 : scan_idx_q;
  end

  // A value whose whole-degree magnitude is zero never shows a minus sign.
  always_comb begin
    load_digits[3] = (raw_q[RAW_W-1] && raw_to_int(raw_q) != '0) ? DIG_MINUS : DIG_BLANK;
    load_digits[2] = conv_bcd[11:8];
    load_digits[1] = conv_bcd[7:4];
    load_digits[0] = conv_bcd[3:0];
`ifdef TEMP_LZB_EN
    if (conv_bcd[11:8] == 4'd0) begin
      load_digits[2] = DIG_BLANK;
      if (conv_bcd[7:4] == 4'd0) begin
        load_digits[1] = DIG_BLANK;
      end
    end
`endif
  end

  // A strobe arriving during LOAD is the newest value, so it outranks the pending one.
  always_comb begin
    state_d    = state_q;
    raw_d      = raw_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    disp_d     = disp_q;
    conv_start = 1'b0;
    conv_raw   = data[15:4];
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          raw_d      = data[15:4];
          conv_start = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (data_valid) begin
          pend_d     = 1'b1;
          pend_val_d = data[15:4];
        end
        if (conv_done) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        disp_d = load_digits;
        pend_d = 1'b0;
        if (data_valid || pend_q) begin
          conv_raw   = data_valid ? data[15:4] : pend_val_q;
          raw_d      = conv_raw;
          conv_start = 1'b1;
          state_d    = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start),
    .bin_i   (raw_to_int(conv_raw)),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt_q <= '0;
      start_q      <= 1'b0;
      scan_cnt_q   <= '0;
      scan_idx_q   <= 2'd0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
      state_q      <= IDLE;
      raw_q        <= '0;
      pend_val_q   <= '0;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
      disp_q       <= {DIG_BLANK, DIG_0, DIG_0, DIG_0};
    end else begin
      sample_cnt_q <= sample_cnt_d;
      start_q      <= (sample_cnt_d == SAMPLE_LAST);
      scan_cnt_q   <= scan_cnt_d;
      scan_idx_q   <= scan_idx_d;
      an_q         <= ~(4'b0001 << scan_idx_q);
      seg_q        <= seg_encode(digit_t'(disp_q[scan_idx_q]));
      state_q      <= state_d;
      raw_q        <= raw_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      busy_q       <= (state_d != IDLE);
      disp_q       <= disp_d;
    end
  end

  assign start = start_q;
  assign busy  = busy_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule
